// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package fifo_word_serializer_pkg;

    // State encoding: ST_IDLE = no word held, ST_SHIFT = a word is being emitted.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_OUT_WIDTH  = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    // Bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int beats_of(input int data_width, input int out_width);
        return data_width / out_width;
    endfunction

    // Beat index width, never narrower than one bit so single-beat builds still elaborate.
    function automatic int idx_width(input int beats);
        return (beats > 1) ? clog2(beats) : 1;
    endfunction

    localparam int BEATS = beats_of(DEF_DATA_WIDTH, DEF_OUT_WIDTH);

endpackage

// File: rtl/fifo_word_serializer_if.sv
// FIFO-read and narrow-stream handshake signals of the word serializer.
interface fifo_word_serializer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
);
    logic                  fifo_is_empty;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_en;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    // Serializer side: reads the FIFO head, drives the beat stream.
    modport master (
        input  fifo_is_empty,
        input  read_data,
        input  out_ready,
        output read_en,
        output out_data,
        output out_valid,
        output out_last
    );

    // Environment side: the FIFO plus the beat consumer.
    modport slave (
        output fifo_is_empty,
        output read_data,
        output out_ready,
        input  read_en,
        input  out_data,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/fifo_word_serializer.sv
// Drains a show-ahead FIFO and emits each word as narrow beats, LSB beat first,
// with no bubble between consecutive words.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no word held; fetch when enabled and the FIFO has data
//   ST_SHIFT | word held; out_valid high, beats shift out on each handshake
module fifo_word_serializer
    import fifo_word_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    fifo_word_serializer_if.master bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_done
);

    localparam int NUM_BEATS = beats_of(DATA_WIDTH, OUT_WIDTH);
    localparam int IDX_W     = idx_width(NUM_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0]      idx;

    logic is_last;
    logic beat_done;
    logic fetch;

    assign is_last   = (state == ST_SHIFT) && (idx == LAST_IDX);
    assign beat_done = (state == ST_SHIFT) && bus.out_ready;

    // Pop the FIFO head when idle, or on the final beat's handshake for zero-bubble
    // reload; gated by reset so no pop leaks out while the block is held in reset.
    assign fetch = reset && enable && !bus.fifo_is_empty &&
                   ((state == ST_IDLE) || (beat_done && is_last));

    assign bus.read_en   = fetch;
    assign bus.out_valid = (state == ST_SHIFT);
    assign bus.out_data  = shift_reg[OUT_WIDTH-1:0];
    assign bus.out_last  = is_last;
    assign busy          = (state == ST_SHIFT);

    // FSM, shift register, beat index and completed-word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            idx        <= '0;
            words_done <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch) begin
                        shift_reg <= bus.read_data;
                        idx       <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (beat_done) begin
                        if (is_last) begin
                            words_done <= words_done + CNT_WIDTH'(1);
                            idx        <= '0;
                            if (fetch) begin
                                shift_reg <= bus.read_data;
                            end else begin
                                // Clear so an idle block presents a zero beat.
                                shift_reg <= '0;
                                state     <= ST_IDLE;
                            end
                        end else begin
                            shift_reg <= shift_reg >> OUT_WIDTH;
                            idx       <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: a queue models the show-ahead FIFO,
// a vector table holds per-cycle stimulus and hand-computed expected outputs.
module tb_fifo_word_serializer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        busy;
    logic [15:0] words_done;

    fifo_word_serializer_if #(.DATA_WIDTH(32), .OUT_WIDTH(8)) bus ();

    fifo_word_serializer #(
        .DATA_WIDTH(32),
        .OUT_WIDTH (8),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus),
        .busy      (busy),
        .words_done(words_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       rdy;
        logic       re;
        logic       vld;
        logic [7:0] data;
        logic       last;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] fifo_q[$];
    int          passed;
    int          total;

    function automatic void row(input logic en, input logic rdy, input logic re,
                                input logic vld, input logic [7:0] data, input logic last);
        vec_t v;
        v.en = en; v.rdy = rdy; v.re = re; v.vld = vld; v.data = data; v.last = last;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive inputs shortly after the falling edge and let combinational outputs settle.
    task automatic drive(input logic en, input logic rdy);
        enable            = en;
        bus.out_ready     = rdy;
        bus.fifo_is_empty = (fifo_q.size() == 0);
        bus.read_data     = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        #1;
    endtask

    // Cross one rising edge; the FIFO model pops when the DUT strobed read_en.
    task automatic advance();
        logic re;
        re = bus.read_en;
        @(posedge clk);
        if (re && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic run_rows(input string tag, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(vecs[i].en, vecs[i].rdy);
            chk($sformatf("%s row%0d read_en", tag, i - lo), 32'(bus.read_en), 32'(vecs[i].re));
            chk($sformatf("%s row%0d out_valid", tag, i - lo), 32'(bus.out_valid), 32'(vecs[i].vld));
            chk($sformatf("%s row%0d busy", tag, i - lo), 32'(busy), 32'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("%s row%0d out_data", tag, i - lo), 32'(bus.out_data), 32'(vecs[i].data));
                chk($sformatf("%s row%0d out_last", tag, i - lo), 32'(bus.out_last), 32'(vecs[i].last));
            end
            advance();
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " read_en"}, 32'(bus.read_en), 32'h0);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
        chk({tag, " out_last"}, 32'(bus.out_last), 32'h0);
        chk({tag, " out_data"}, 32'(bus.out_data), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " words_done"}, 32'(words_done), 32'h0);
    endtask

    initial begin
        int s_idle, s_single, s_b2b, s_bp, s_en, s_rst, s_end;
        passed = 0;
        total  = 0;

        // Idle with empty FIFO after reset release.
        s_idle = vecs.size();
        row(1, 1, 0, 0, 8'h00, 0);
        row(1, 1, 0, 0, 8'h00, 0);
        // Single word A1B2C3D4, LSB beat first.
        s_single = vecs.size();
        row(1, 1, 1, 0, 8'h00, 0);
        row(1, 1, 0, 1, 8'hD4, 0);
        row(1, 1, 0, 1, 8'hC3, 0);
        row(1, 1, 0, 1, 8'hB2, 0);
        row(1, 1, 0, 1, 8'hA1, 1);
        row(1, 1, 0, 0, 8'h00, 0);
        // Back-to-back words: zero-bubble reload on the last beat of the first word.
        s_b2b = vecs.size();
        row(1, 1, 1, 0, 8'h00, 0);
        row(1, 1, 0, 1, 8'h00, 0);
        row(1, 1, 0, 1, 8'h01, 0);
        row(1, 1, 0, 1, 8'h02, 0);
        row(1, 1, 1, 1, 8'h03, 1);
        row(1, 1, 0, 1, 8'h04, 0);
        row(1, 1, 0, 1, 8'h05, 0);
        row(1, 1, 0, 1, 8'h06, 0);
        row(1, 1, 0, 1, 8'h07, 1);
        row(1, 1, 0, 0, 8'h00, 0);
        // Backpressure on DEADBEEF: every beat stalled twice before acceptance.
        s_bp = vecs.size();
        row(1, 1, 1, 0, 8'h00, 0);
        row(1, 0, 0, 1, 8'hEF, 0);
        row(1, 0, 0, 1, 8'hEF, 0);
        row(1, 1, 0, 1, 8'hEF, 0);
        row(1, 0, 0, 1, 8'hBE, 0);
        row(1, 0, 0, 1, 8'hBE, 0);
        row(1, 1, 0, 1, 8'hBE, 0);
        row(1, 0, 0, 1, 8'hAD, 0);
        row(1, 0, 0, 1, 8'hAD, 0);
        row(1, 1, 0, 1, 8'hAD, 0);
        row(1, 0, 0, 1, 8'hDE, 1);
        row(1, 0, 0, 1, 8'hDE, 1);
        row(1, 1, 0, 1, 8'hDE, 1);
        row(1, 1, 0, 0, 8'h00, 0);
        // Enable boundary: no fetch while disabled, drop enable mid-word.
        s_en = vecs.size();
        row(0, 1, 0, 0, 8'h00, 0);
        row(0, 1, 0, 0, 8'h00, 0);
        row(0, 1, 0, 0, 8'h00, 0);
        row(1, 1, 1, 0, 8'h00, 0);
        row(0, 1, 0, 1, 8'h44, 0);
        row(0, 1, 0, 1, 8'h33, 0);
        row(0, 1, 0, 1, 8'h22, 0);
        row(0, 1, 0, 1, 8'h11, 1);
        row(0, 1, 0, 0, 8'h00, 0);
        row(0, 1, 0, 0, 8'h00, 0);
        // After a mid-word reset the next queued word starts at beat 0.
        s_rst = vecs.size();
        row(1, 1, 1, 0, 8'h00, 0);
        row(1, 1, 0, 1, 8'hCC, 0);
        row(1, 1, 0, 1, 8'hBB, 0);
        row(1, 1, 0, 1, 8'hAA, 0);
        row(1, 1, 0, 1, 8'h99, 1);
        row(1, 1, 0, 0, 8'h00, 0);
        s_end = vecs.size();

        // Reset held for three cycles with an empty FIFO.
        reset = 1'b0;
        drive(1, 1);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            drive(1, 1);
            chk_cleared($sformatf("reset c%0d", c));
            advance();
        end
        reset = 1'b1;
        run_rows("idle", s_idle, s_single);

        fifo_q.push_back(32'hA1B2C3D4);
        run_rows("single", s_single, s_b2b);
        chk("single words_done", 32'(words_done), 32'd1);

        fifo_q.push_back(32'h03020100);
        fifo_q.push_back(32'h07060504);
        run_rows("b2b", s_b2b, s_bp);
        chk("b2b words_done", 32'(words_done), 32'd3);

        fifo_q.push_back(32'hDEADBEEF);
        run_rows("bp", s_bp, s_en);
        chk("bp words_done", 32'(words_done), 32'd4);

        fifo_q.push_back(32'h11223344);
        fifo_q.push_back(32'h55667788);
        run_rows("en", s_en, s_rst);
        chk("en words_done", 32'(words_done), 32'd5);
        chk("en queued words left", 32'(fifo_q.size()), 32'd1);

        // Start 55667788, accept two beats, then reset mid-word.
        drive(1, 1);
        chk("midrst fetch read_en", 32'(bus.read_en), 32'd1);
        advance();
        drive(1, 1);
        chk("midrst beat0", 32'(bus.out_data), 32'h88);
        advance();
        drive(1, 1);
        chk("midrst beat1", 32'(bus.out_data), 32'h77);
        advance();
        chk("midrst holding", 32'(bus.out_valid), 32'd1);
        fifo_q.push_back(32'h99AABBCC);
        reset = 1'b0;
        drive(1, 1);
        chk_cleared("midrst asserted");
        advance();
        drive(1, 1);
        chk_cleared("midrst held");
        advance();
        reset = 1'b1;
        run_rows("after_rst", s_rst, s_end);
        chk("after_rst words_done", 32'(words_done), 32'd1);
        chk("after_rst queue empty", 32'(fifo_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
